// File: rtl/pakin_fifo_pkg.sv
// Shared channel macros (field widths, on/off, channel declarations, packing order)
// plus the FSM state types used by pakin_fifo.
`ifndef HGLOBAL_V
`define HGLOBAL_V
`define NS_ADDRESS_SIZE 4
`define NS_DATA_SIZE    4
`define NS_REDUN_SIZE   4
`define NS_PACKET_SIZE  ((2 * `NS_ADDRESS_SIZE) + `NS_DATA_SIZE + `NS_REDUN_SIZE)
`define NS_ON  1'b1
`define NS_OFF 1'b0
`define NS_DECLARE_IN_CHNL(c_src, c_dst, c_dat, c_red, c_req, c_ack) \
  input  logic [ASZ-1:0] c_src, \
  input  logic [ASZ-1:0] c_dst, \
  input  logic [DSZ-1:0] c_dat, \
  input  logic [RSZ-1:0] c_red, \
  input  logic           c_req, \
  output logic           c_ack
`define NS_DECLARE_OUT_CHNL(c_src, c_dst, c_dat, c_red, c_req, c_ack) \
  output logic [ASZ-1:0] c_src, \
  output logic [ASZ-1:0] c_dst, \
  output logic [DSZ-1:0] c_dat, \
  output logic [RSZ-1:0] c_red, \
  output logic           c_req, \
  input  logic           c_ack
// Packing order, msb first: {src, dst, dat, red}
`define NS_PACK(c_src, c_dst, c_dat, c_red) {c_src, c_dst, c_dat, c_red}
`endif

package pakin_fifo_pkg;
  typedef enum logic {I_IDLE, I_ACK} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_WAIT} out_state_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/pakin_fifo_mem.sv
// DEPTH x PSZ packet store with wrapping pointers and occupancy count.
// The head word is read combinationally so a fresh push is visible on the next edge.
module pakin_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int PSZ   = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PSZ-1:0]           wdata,
  output logic                     full,
  output logic                     empty,
  output logic [PSZ-1:0]           head,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);
  import pakin_fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PSZ-1:0] mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  cnt_reg;
  logic           do_push, do_pop;

  assign full     = (cnt_reg == CW'(DEPTH));
  assign empty    = (cnt_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head     = mem_reg[rd_ptr_reg];
  assign fifo_cnt = cnt_reg;

  // Storage is not reset; discarding contents only needs the pointers cleared.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == AW'(gi)))
        mem_reg[gi] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end
endmodule

// File: rtl/pakin_fifo.sv
// Packet receive buffer: four-phase input channel, destination filter, FIFO,
// four-phase output channel.
module pakin_fifo #(
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 1,
  parameter int DEPTH    = 4,
  parameter int ASZ      = `NS_ADDRESS_SIZE,
  parameter int DSZ      = `NS_DATA_SIZE,
  parameter int RSZ      = `NS_REDUN_SIZE,
  parameter int PSZ      = `NS_PACKET_SIZE
) (
  input  logic                   i_clk,
  input  logic                   reset,
  `NS_DECLARE_IN_CHNL(i0_src, i0_dst, i0_dat, i0_red, i0_req, i0_ack),
  `NS_DECLARE_OUT_CHNL(o0_src, o0_dst, o0_dat, o0_red, o0_req, o0_ack),
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_cnt
);
  import pakin_fifo_pkg::*;

  localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);

  in_state_t      i_state_reg;
  out_state_t     o_state_reg;
  logic           addr_ok, push, pop, full, empty;
  logic [PSZ-1:0] head;
  logic [PSZ-1:0] wdata;

  assign addr_ok = (i0_dst >= MIN_A) && (i0_dst <= MAX_A);
  assign push    = (i_state_reg == I_IDLE) && i0_req && addr_ok && !full;
  assign pop     = (o_state_reg == O_REQ) && o0_ack;
  assign wdata   = `NS_PACK(i0_src, i0_dst, i0_dat, i0_red);

  pakin_fifo_mem #(
    .DEPTH (DEPTH),
    .PSZ   (PSZ)
  ) u_mem (
    .clk      (i_clk),
    .srst     (reset),
    .push     (push),
    .pop      (pop),
    .wdata    (wdata),
    .full     (full),
    .empty    (empty),
    .head     (head),
    .fifo_cnt (fifo_cnt)
  );

  // Filtered packets are acknowledged regardless of occupancy so a full FIFO
  // never stalls traffic that would be discarded anyway.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      i_state_reg <= I_IDLE;
      i0_ack      <= `NS_OFF;
      drop_cnt    <= '0;
    end else begin
      case (i_state_reg)
        I_IDLE: begin
          if (i0_req && !addr_ok) begin
            drop_cnt    <= sat_inc8(drop_cnt);
            i0_ack      <= `NS_ON;
            i_state_reg <= I_ACK;
          end else if (i0_req && !full) begin
            i0_ack      <= `NS_ON;
            i_state_reg <= I_ACK;
          end
        end
        I_ACK: begin
          if (!i0_req) begin
            i0_ack      <= `NS_OFF;
            i_state_reg <= I_IDLE;
          end
        end
        default: i_state_reg <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      o_state_reg  <= O_IDLE;
      o0_req       <= `NS_OFF;
      `NS_PACK(o0_src, o0_dst, o0_dat, o0_red) <= '0;
    end else begin
      case (o_state_reg)
        O_IDLE: begin
          if (!empty && !o0_ack) begin
            `NS_PACK(o0_src, o0_dst, o0_dat, o0_red) <= head;
            o0_req       <= `NS_ON;
            o_state_reg  <= O_REQ;
          end
        end
        O_REQ: begin
          if (o0_ack) begin
            o0_req      <= `NS_OFF;
            o_state_reg <= O_WAIT;
          end
        end
        O_WAIT: begin
          if (!o0_ack) o_state_reg <= O_IDLE;
        end
        default: o_state_reg <= O_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pakin_fifo.sv
// Self-checking bench for pakin_fifo: vector table, scoreboarded sink, and
// hand-written full/reset/saturation sequences.
module tb_pakin_fifo;
  localparam int DEPTH = 4;

  logic       i_clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] i0_src, i0_dst, i0_dat, i0_red;
  logic       i0_req, i0_ack;
  logic [3:0] o0_src, o0_dst, o0_dat, o0_red;
  logic       o0_req, o0_ack;
  logic [7:0] drop_cnt;
  logic [2:0] fifo_cnt;

  always #5 i_clk = ~i_clk;

  pakin_fifo #(
    .MIN_ADDR (1), .MAX_ADDR (1), .DEPTH (DEPTH),
    .ASZ (4), .DSZ (4), .RSZ (4), .PSZ (16)
  ) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .i0_src   (i0_src),
    .i0_dst   (i0_dst),
    .i0_dat   (i0_dat),
    .i0_red   (i0_red),
    .i0_req   (i0_req),
    .i0_ack   (i0_ack),
    .o0_src   (o0_src),
    .o0_dst   (o0_dst),
    .o0_dat   (o0_dat),
    .o0_red   (o0_red),
    .o0_req   (o0_req),
    .o0_ack   (o0_ack),
    .drop_cnt (drop_cnt),
    .fifo_cnt (fifo_cnt)
  );

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
    logic [3:0] dat;
    logic [3:0] red;
    bit         acc;
  } vec_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] sb[$];
  bit          sink_en  = 1'b0;
  int          delivered = 0;
  int          max_cnt  = 0;
  int          exp_drop = 0;
  vec_t        tbl[6];

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Downstream peer: acks every request, checks payload against the scoreboard.
  initial begin
    o0_ack = 1'b0;
    forever begin
      @(negedge i_clk);
      if (32'(fifo_cnt) > max_cnt) max_cnt = 32'(fifo_cnt);
      if (reset) begin
        o0_ack = 1'b0;
      end else if (sink_en && o0_req && !o0_ack) begin
        if (sb.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_pkt: got %h expected none", {o0_src, o0_dst, o0_dat, o0_red});
        end else begin
          check("out_payload", 32'({o0_src, o0_dst, o0_dat, o0_red}), 32'(sb.pop_front()));
        end
        delivered++;
        o0_ack = 1'b1;
      end else if (o0_ack && !o0_req) begin
        o0_ack = 1'b0;
      end
    end
  end

  task automatic send(input logic [3:0] s, input logic [3:0] d, input logic [3:0] da,
                      input logic [3:0] r, input bit acc, input bit chk_lat);
    int n;
    @(negedge i_clk);
    i0_src = s; i0_dst = d; i0_dat = da; i0_red = r;
    i0_req = 1'b1;
    if (acc) sb.push_back({s, d, da, r});
    else     exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!i0_ack && n < 50);
    if (chk_lat) check("ack_latency", n, 1);
    if (!i0_ack) check("ack_timeout", 32'(i0_ack), 1);
    i0_req = 1'b0;
    n = 0;
    do begin @(negedge i_clk); n++; end while (i0_ack && n < 50);
    if (i0_ack) check("ack_fall_timeout", 32'(i0_ack), 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || o0_req || o0_ack || fifo_cnt != 0) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int n, d0;
    i0_src = '0; i0_dst = '0; i0_dat = '0; i0_red = '0; i0_req = 1'b0;
    tbl[0] = '{src: 4'd3,  dst: 4'd1,  dat: 4'd5,  red: 4'd15, acc: 1'b1};
    tbl[1] = '{src: 4'd2,  dst: 4'd2,  dat: 4'd7,  red: 4'd0,  acc: 1'b0};
    tbl[2] = '{src: 4'd0,  dst: 4'd0,  dat: 4'd1,  red: 4'd1,  acc: 1'b0};
    tbl[3] = '{src: 4'd15, dst: 4'd1,  dat: 4'd0,  red: 4'd0,  acc: 1'b1};
    tbl[4] = '{src: 4'd9,  dst: 4'd15, dat: 4'd9,  red: 4'd9,  acc: 1'b0};
    tbl[5] = '{src: 4'd1,  dst: 4'd1,  dat: 4'd15, red: 4'd10, acc: 1'b1};

    repeat (3) @(negedge i_clk);
    check("rst_i0_ack", 32'(i0_ack), 0);
    check("rst_o0_req", 32'(o0_req), 0);
    check("rst_payload", 32'({o0_src, o0_dst, o0_dat, o0_red}), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_fifo_cnt", 32'(fifo_cnt), 0);
    reset = 1'b0;
    sink_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].src, tbl[i].dst, tbl[i].dat, tbl[i].red, tbl[i].acc, 1'b1);
      if (!tbl[i].acc) check("drop_no_req", 32'(o0_req), 0);
      wait_drain();
      check("vec_drop_cnt", 32'(drop_cnt), exp_drop);
      check("vec_fifo_cnt", 32'(fifo_cnt), 0);
      $display("vec %0d: dst=%0d acc=%0d drop_cnt=%0d", i, tbl[i].dst, tbl[i].acc, drop_cnt);
    end

    // Full FIFO with a stalled sink, then release.
    sink_en = 1'b0;
    for (int k = 0; k < 4; k++) send(4'd2, 4'd1, 4'(k), 4'd0, 1'b1, 1'b1);
    repeat (2) @(negedge i_clk);
    check("full_cnt", 32'(fifo_cnt), DEPTH);
    check("full_o0_req", 32'(o0_req), 1);
    @(negedge i_clk);
    i0_src = 4'd2; i0_dst = 4'd1; i0_dat = 4'd4; i0_red = 4'd0; i0_req = 1'b1;
    sb.push_back({4'd2, 4'd1, 4'd4, 4'd0});
    repeat (8) @(negedge i_clk);
    check("full_ack_held", 32'(i0_ack), 0);
    check("full_cnt_held", 32'(fifo_cnt), DEPTH);
    sink_en = 1'b1;
    n = 0;
    while (!i0_ack && n < 20) begin @(negedge i_clk); n++; end
    check("fifth_accepted", 32'(i0_ack), 1);
    i0_req = 1'b0;
    n = 0;
    while (i0_ack && n < 20) begin @(negedge i_clk); n++; end
    wait_drain();
    check("full_drained", 32'(fifo_cnt), 0);
    $display("full test: delivered=%0d", delivered);

    // Both peers at full rate, pointers wrap several times.
    max_cnt = 0;
    d0 = delivered;
    for (int k = 0; k < 20; k++) send(4'(k), 4'd1, 4'(k * 7), 4'(15 - k), 1'b1, 1'b0);
    wait_drain();
    check("rate_delivered", delivered - d0, 20);
    check("rate_max_cnt_ok", int'(max_cnt <= DEPTH), 1);
    $display("rate test: delivered=%0d max_cnt=%0d", delivered - d0, max_cnt);

    // Reset while a request is outstanding downstream.
    sink_en = 1'b0;
    send(4'd4, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) send(4'd5, 4'd1, 4'(k + 8), 4'd1, 1'b1, 1'b1);
    repeat (2) @(negedge i_clk);
    check("pre_rst_o0_req", 32'(o0_req), 1);
    check("pre_rst_cnt", 32'(fifo_cnt), 3);
    reset = 1'b1;
    @(negedge i_clk);
    check("mid_rst_o0_req", 32'(o0_req), 0);
    check("mid_rst_i0_ack", 32'(i0_ack), 0);
    check("mid_rst_cnt", 32'(fifo_cnt), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    check("mid_rst_dat", 32'(o0_dat), 0);
    reset = 1'b0;
    sb.delete();
    exp_drop = 0;
    sink_en = 1'b1;
    d0 = delivered;
    send(4'd7, 4'd1, 4'd10, 4'd3, 1'b1, 1'b1);
    wait_drain();
    check("post_rst_delivered", delivered - d0, 1);
    $display("reset test: delivered=%0d", delivered - d0);

    // Drop counter saturation.
    for (int k = 0; k < 300; k++) send(4'd0, 4'd2, 4'(k), 4'd0, 1'b0, 1'b0);
    check("drop_sat_model", 32'(drop_cnt), exp_drop);
    check("drop_sat_255", 32'(drop_cnt), 255);
    check("drop_sat_no_req", 32'(o0_req), 0);
    $display("saturation test: drop_cnt=%0d", drop_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
